// File: rtl/pe_depacketizer.sv
// PE depacketizer: accepts a routed PE packet, drops packets whose hop
// counters are not exhausted, presents the decoded fields to a consumer,
// then returns a short ACK packet to the sender before taking the next one.
module pe_depacketizer #(
    parameter int         FILTER_WIDTH  = 8,
    parameter int         OUTPUT_WIDTH  = 13,
    parameter logic [1:0] ACK_DIRECTION = 2'd1,
    parameter logic [2:0] ACK_X_HOP     = 3'd2,
    parameter logic [2:0] ACK_Y_HOP     = 3'd1,
    localparam int        PW            = 13 + 5 * FILTER_WIDTH,
    localparam int        CW            = 5 * FILTER_WIDTH - 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PW-1:0]           pkt_in,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    output logic [CW-1:0]           conv_loc,
    output logic [OUTPUT_WIDTH-1:0] residue,
    output logic [3:0]              pe_node,
    output logic                    outspike,
    output logic                    timestep,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [PW-1:0]           ack_out,
    output logic                    ack_valid,
    input  logic                    ack_ready,
    output logic [15:0]             spike_cnt,
    output logic [7:0]              err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        ACK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          init_done;
    logic [PW-9:0] pkt_reg;
    logic          accept;
    logic          malformed;
    logic          unused_dir;

    // Only bits [PW-1:8] carry payload; hops [7:2] are checked on the fly
    // and the direction bits [1:0] play no part in classification.
    assign accept     = pkt_valid && pkt_ready;
    assign malformed  = (pkt_in[7:5] != 3'd0) || (pkt_in[4:2] != 3'd0);
    assign unused_dir = ^pkt_in[1:0];

    assign conv_loc = pkt_reg[PW-9:19];
    assign residue  = pkt_reg[6 +: OUTPUT_WIDTH];
    assign pe_node  = pkt_reg[5:2];
    assign outspike = pkt_reg[1];
    assign timestep = pkt_reg[0];

    // State register; reset abandons whatever packet was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Keeps pkt_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Next-state: accept well-formed packets, wait for consumer, then for ACK sink.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !malformed) state_next = EMIT;
            EMIT:    if (dec_ready)            state_next = ACK;
            ACK:     if (ack_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Outputs: handshake flags and the ACK packet decoded from the state.
    always_comb begin
        pkt_ready = 1'b0;
        dec_valid = 1'b0;
        ack_valid = 1'b0;
        ack_out   = '0;
        case (state)
            IDLE: pkt_ready = init_done;
            EMIT: dec_valid = 1'b1;
            ACK: begin
                ack_valid = 1'b1;
                ack_out   = {{(PW-13){1'b0}}, pe_node, 1'b1,
                             ACK_Y_HOP, ACK_X_HOP, ACK_DIRECTION};
            end
            default: pkt_ready = 1'b0;
        endcase
    end

    // Payload capture on every accepted packet; only shown while dec_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_reg <= '0;
        end else if (accept) begin
            pkt_reg <= pkt_in[PW-1:8];
        end
    end

    // Saturating counters for accepted spikes and dropped malformed packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= '0;
            err_cnt   <= '0;
        end else if (accept) begin
            if (malformed) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (pkt_in[9]) begin
                if (spike_cnt != 16'hFFFF) spike_cnt <= spike_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pe_depacketizer.sv
// Testbench for pe_depacketizer: directed packets, a transaction-level model
// checked every cycle, and literal expectations for the key scenarios.
module tb_pe_depacketizer;

    localparam int PW = 53;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] pkt_in;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [25:0]   conv_loc;
    logic [12:0]   residue;
    logic [3:0]    pe_node;
    logic          outspike;
    logic          timestep;
    logic          dec_valid;
    logic          dec_ready;
    logic [PW-1:0] ack_out;
    logic          ack_valid;
    logic          ack_ready;
    logic [15:0]   spike_cnt;
    logic [7:0]    err_cnt;

    int checks = 0;
    int fails  = 0;
    int dec_hs = 0;
    int ack_hs = 0;

    // Model state: is a packet held, has it been handed to the consumer.
    bit            m_init;
    bit            m_busy;
    bit            m_decoded;
    logic [PW-1:0] m_pkt;
    int            m_spike;
    int            m_err;

    pe_depacketizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_in    (pkt_in),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .conv_loc  (conv_loc),
        .residue   (residue),
        .pe_node   (pe_node),
        .outspike  (outspike),
        .timestep  (timestep),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .ack_out   (ack_out),
        .ack_valid (ack_valid),
        .ack_ready (ack_ready),
        .spike_cnt (spike_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [PW-1:0] make_pkt(input logic [25:0] conv, input logic [12:0] res,
                                               input logic [3:0] node, input logic os,
                                               input logic ts, input logic [2:0] yh,
                                               input logic [2:0] xh, input logic [1:0] dir);
        return {conv, res, node, os, ts, yh, xh, dir};
    endfunction

    // Transaction model: one packet in flight, decode then ACK, saturating counts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init    = 1'b0;
            m_busy    = 1'b0;
            m_decoded = 1'b0;
            m_pkt     = '0;
            m_spike   = 0;
            m_err     = 0;
        end else begin
            if (!m_busy) begin
                if (m_init && pkt_valid) begin
                    if (pkt_in[7:5] != 3'd0 || pkt_in[4:2] != 3'd0) begin
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                    end else begin
                        m_busy    = 1'b1;
                        m_decoded = 1'b0;
                        m_pkt     = pkt_in;
                        if (pkt_in[9]) m_spike = (m_spike < 65535) ? m_spike + 1 : 65535;
                    end
                end
            end else if (!m_decoded) begin
                if (dec_ready) m_decoded = 1'b1;
            end else if (ack_ready) begin
                m_busy = 1'b0;
            end
            m_init = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [PW-1:0] exp_ack;
        exp_ack = '0;
        if (m_busy && m_decoded)
            exp_ack = {40'b0, m_pkt[13:10], 1'b1, 3'd1, 3'd2, 2'd1};
        check_output("model_pkt_ready", pkt_ready, m_init && !m_busy);
        check_output("model_dec_valid", dec_valid, m_busy && !m_decoded);
        check_output("model_ack_valid", ack_valid, m_busy && m_decoded);
        check_output("model_ack_out", ack_out, exp_ack);
        check_output("model_spike_cnt", spike_cnt, 64'(m_spike));
        check_output("model_err_cnt", err_cnt, 64'(m_err));
        check_output("dec_ack_exclusive", dec_valid & ack_valid, 0);
        if (m_busy && !m_decoded) begin
            check_output("model_conv_loc", conv_loc, m_pkt[52:27]);
            check_output("model_residue", residue, m_pkt[26:14]);
            check_output("model_pe_node", pe_node, m_pkt[13:10]);
            check_output("model_outspike", outspike, m_pkt[9]);
            check_output("model_timestep", timestep, m_pkt[8]);
        end
        if (dec_valid && dec_ready) dec_hs++;
        if (ack_valid && ack_ready) ack_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [PW-1:0] p);
        pkt_in    = p;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
    endtask

    // Directed scenario sequence.
    initial begin
        logic [PW-1:0] p1, p2, p3, p4;
        pkt_in    = '0;
        pkt_valid = 1'b0;
        dec_ready = 1'b0;
        ack_ready = 1'b0;
        p1 = make_pkt(26'hABC, 13'h123, 4'd5, 1'b1, 1'b0, 3'd0, 3'd0, 2'd2);
        p2 = make_pkt(26'h1, 13'h2, 4'd3, 1'b1, 1'b0, 3'd0, 3'd3, 2'd0);
        p3 = make_pkt(26'h3FFFFFF, 13'h1FFF, 4'hF, 1'b0, 1'b1, 3'd0, 3'd0, 2'd3);
        p4 = make_pkt(26'h155, 13'h0AA, 4'd9, 1'b1, 1'b1, 3'd0, 3'd0, 2'd1);

        #1 rst_n = 1'b0;
        #1;
        check_output("rst_pkt_ready", pkt_ready, 0);
        check_output("rst_dec_valid", dec_valid, 0);
        check_output("rst_ack_valid", ack_valid, 0);
        check_output("rst_ack_out", ack_out, 0);
        check_output("rst_conv_loc", conv_loc, 0);
        check_output("rst_spike_cnt", spike_cnt, 0);
        check_output("rst_err_cnt", err_cnt, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        #1 check_output("ready_before_edge", pkt_ready, 0);
        tick();
        check_output("ready_after_edge", pkt_ready, 1);

        // Basic decode and ACK with defaults.
        apply_stimulus(p1);
        check_output("p1_dec_valid", dec_valid, 1);
        check_output("p1_conv_loc", conv_loc, 26'hABC);
        check_output("p1_residue", residue, 13'h123);
        check_output("p1_pe_node", pe_node, 5);
        check_output("p1_outspike", outspike, 1);
        check_output("p1_timestep", timestep, 0);
        check_output("p1_spike_cnt", spike_cnt, 1);
        check_output("p1_pkt_ready", pkt_ready, 0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check_output("p1_dec_fall", dec_valid, 0);
        check_output("p1_ack_valid", ack_valid, 1);
        check_output("p1_ack_out", ack_out, 53'hB29);
        tick();
        check_output("p1_ack_hold", ack_out, 53'hB29);
        ack_ready = 1'b1;
        tick();
        ack_ready = 1'b0;
        check_output("p1_ack_done", ack_valid, 0);
        check_output("p1_ready_again", pkt_ready, 1);

        // Malformed packet (x-hop=3) is dropped.
        apply_stimulus(p2);
        check_output("p2_dec_valid", dec_valid, 0);
        check_output("p2_ack_valid", ack_valid, 0);
        check_output("p2_err_cnt", err_cnt, 1);
        check_output("p2_pkt_ready", pkt_ready, 1);
        check_output("p2_spike_cnt", spike_cnt, 1);

        // Direction bits ignored; consumer stalls for 10 cycles.
        apply_stimulus(p3);
        check_output("p3_dec_valid", dec_valid, 1);
        check_output("p3_spike_cnt", spike_cnt, 1);
        pkt_in    = p1;
        pkt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("stall_dec_valid", dec_valid, 1);
            check_output("stall_pkt_ready", pkt_ready, 0);
            check_output("stall_conv_loc", conv_loc, 26'h3FFFFFF);
            check_output("stall_residue", residue, 13'h1FFF);
        end
        pkt_valid = 1'b0;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check_output("p3_ack_out", ack_out, 53'h1F29);
        tick();
        check_output("p3_ack_valid", ack_valid, 1);

        // Reset asynchronously while ACK is pending.
        rst_n = 1'b0;
        #1;
        check_output("arst_ack_valid", ack_valid, 0);
        check_output("arst_ack_out", ack_out, 0);
        check_output("arst_spike_cnt", spike_cnt, 0);
        check_output("arst_err_cnt", err_cnt, 0);
        check_output("arst_pkt_ready", pkt_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("arst_ready_back", pkt_ready, 1);
        apply_stimulus(p1);
        check_output("arst_next_dec", dec_valid, 1);
        check_output("arst_next_spike", spike_cnt, 1);
        dec_ready = 1'b1;
        tick();
        ack_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        ack_ready = 1'b0;
        check_output("arst_next_done", pkt_ready, 1);

        // Duplicate timestep packets back-to-back with consumers always ready.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        dec_hs    = 0;
        ack_hs    = 0;
        dec_ready = 1'b1;
        ack_ready = 1'b1;
        pkt_in    = p4;
        pkt_valid = 1'b1;
        repeat (4) tick();
        pkt_valid = 1'b0;
        repeat (4) tick();
        check_output("dup_dec_transfers", dec_hs, 2);
        check_output("dup_ack_transfers", ack_hs, 2);
        check_output("dup_spike_cnt", spike_cnt, 2);
        dec_ready = 1'b0;
        ack_ready = 1'b0;

        // 300 malformed packets saturate the error counter.
        pkt_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pkt_in = make_pkt(26'(i), 13'(i), 4'(i), 1'(i), 1'b0,
                              (i % 3 == 0) ? 3'(i % 7 + 1) : 3'd0,
                              (i % 3 != 0) ? 3'(i % 5 + 1) : 3'd0, 2'(i));
            tick();
        end
        pkt_valid = 1'b0;
        tick();
        check_output("sat_err_cnt", err_cnt, 255);
        check_output("sat_dec_valid", dec_valid, 0);
        check_output("sat_spike_cnt", spike_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pe_depacketizer.md
PE_DEPACKETIZER -- requirements
Module: pe_depacketizer

Interface
REQ-001 Parameter FILTER_WIDTH, default 8, sets the conv_loc width; packet width PW = 13+5*FILTER_WIDTH (53 at default).
REQ-002 Parameter OUTPUT_WIDTH, default 13, residue field width.
REQ-003 Parameter ACK_DIRECTION, default 1, 2-bit direction field of generated ACK.
REQ-004 Parameter ACK_X_HOP, default 2, 3-bit x-hop of generated ACK.
REQ-005 Parameter ACK_Y_HOP, default 1, 3-bit y-hop of generated ACK.
REQ-006 The block SHALL use one clock, clk, input, 1 bit, rising-edge; all state is clocked on it.
REQ-007 The block SHALL use reset rst_n, input, 1 bit, asynchronous, active-low.
REQ-008 pkt_in  input  PW  received PE packet.
REQ-009 pkt_valid  input  1  pkt_in valid; pkt_ready  output  1  block can accept.
REQ-010 conv_loc  output  5*FILTER_WIDTH-14  decoded bits [PW-1:27].
REQ-011 residue  output  OUTPUT_WIDTH  decoded bits [26:14].
REQ-012 pe_node  output  4  decoded bits [13:10].
REQ-013 outspike  output  1  bit [9]; timestep  output  1  bit [8].
REQ-014 dec_valid  output  1  decoded fields valid; dec_ready  input  1  consumer accepts.
REQ-015 ack_out  output  PW  ACK packet; ack_valid  output  1; ack_ready  input  1.
REQ-016 spike_cnt  output  16  accepted well-formed packets with outspike=1.
REQ-017 err_cnt  output  8  dropped malformed packets.

Function
REQ-018 FSM states: IDLE, EMIT, ACK.
REQ-019 pkt_ready SHALL be 1 only in IDLE; a transfer occurs when pkt_valid and pkt_ready are both 1 on a rising edge.
REQ-020 On transfer, the block SHALL register pkt_in and classify it: malformed if bits [7:5] or [4:2] are nonzero (hops not exhausted at destination).
REQ-021 A malformed packet SHALL be dropped: FSM stays in IDLE, err_cnt increments by 1 (saturating at 255), no dec_valid, no ACK.
REQ-022 A well-formed packet SHALL move the FSM to EMIT; dec_valid rises the cycle after transfer (latency 1), and spike_cnt increments by 1 (saturating at 65535) if bit [9]=1.
REQ-023 In EMIT, decoded outputs and dec_valid SHALL hold stable until dec_ready=1; on that edge the FSM moves to ACK and dec_valid falls.
REQ-024 In ACK, ack_valid=1 and ack_out = {zeros[PW-1:13], pe_node[3:0], 1'b1, ACK_Y_HOP[2:0], ACK_X_HOP[2:0], ACK_DIRECTION[1:0]}, held stable until ack_ready=1.
REQ-025 On the ack_ready handshake, the FSM SHALL return to IDLE; pkt_ready is 1 the next cycle. There is no bypass, so minimum spacing is 3 cycles per packet.
REQ-026 Direction bits [1:0] SHALL be ignored for classification.
REQ-027 Duplicate packets (timestep=1 packets arrive twice) SHALL each be processed independently, each producing one dec transfer, one ACK, and its own spike_cnt increment.
REQ-028 dec_valid and ack_valid SHALL never be 1 simultaneously.
REQ-029 dec_ready asserted outside EMIT, and ack_ready asserted outside ACK, SHALL have no effect.

Reset
REQ-030 On rst_n=0, the block SHALL immediately (asynchronously) enter IDLE with pkt_ready=0, dec_valid=0, ack_valid=0, all decoded outputs 0, ack_out=0, spike_cnt=0, err_cnt=0.
REQ-031 pkt_ready SHALL become 1 on the first rising clk edge after rst_n rises.
REQ-032 Reset asserted in EMIT or ACK SHALL abandon the packet; no ACK is ever sent for it.

Verification
REQ-033 Packet conv_loc=0xABC, residue=0x123, pe_node=5, outspike=1, timestep=0, hops=0, dir=2 -> dec_valid one cycle later with those fields; spike_cnt=1; after dec_ready, ack_out=0xB29 with defaults.
REQ-034 Packet with x-hop=3 -> no dec_valid, no ack_valid, err_cnt=1, pkt_ready stays 1.
REQ-035 Same timestep=1, outspike=1 packet sent twice back-to-back with ready held 1 -> two dec transfers, two ACKs, spike_cnt=2.
REQ-036 dec_ready held 0 for 10 cycles -> fields and dec_valid stable, pkt_ready=0 throughout.
REQ-037 rst_n pulsed low while ack_valid=1 -> ack_valid=0 with no clock edge, counters 0, next packet processed normally.
REQ-038 300 malformed packets -> err_cnt saturates at 255.
